// File: rtl/digit_scroll_display.sv
// Paged 7-segment viewer for a buffered decimal digit string.
// LOAD collects digits over valid/ready; SHOW pages through them on a timer or step pulses.
module digit_scroll_display #(
  parameter int unsigned NUM_HEX     = 6,
  parameter int unsigned IDX_DIGITS  = 2,
  parameter int unsigned DEPTH       = 150,
  parameter int unsigned STEP        = 4,
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [3:0]             in_digit,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   mode_auto,
  input  logic                   pause,
  input  logic                   step_next,
  input  logic                   step_prev,
  output logic [7*NUM_HEX-1:0]   hex,
  output logic [11:0]            page,
  output logic [11:0]            count,
  output logic                   loaded
);

  localparam int unsigned W   = NUM_HEX - IDX_DIGITS;
  localparam int unsigned CW  = 12;
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned AW  = 16;
  localparam int unsigned BW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic {LOAD, SHOW} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        page_q, page_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [7*NUM_HEX-1:0] hex_q, hex_d;
  logic                 loaded_q;
  logic [3:0]           buf_q [DEPTH];
  logic                 we_c;
  logic                 tick_c;
  logic [CW-1:0]        last_page_c;
  logic [CW-1:0]        page_inc_c;
  logic [CW-1:0]        page_dec_c;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign in_ready    = (state_q == LOAD) && (count_q < CW'(DEPTH));
  assign tick_c      = (timer_q == TW'(TICK_CYCLES - 1));
  // Last page index is ceil(count/STEP)-1; only meaningful in SHOW where count >= 1.
  assign last_page_c = CW'((CW1'(count_q) + CW1'(STEP - 1)) / CW1'(STEP)) - CW'(1);
  assign page_inc_c  = (page_q == last_page_c) ? '0 : page_q + CW'(1);
  assign page_dec_c  = (page_q == '0) ? last_page_c : page_q - CW'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    page_d  = page_q;
    timer_d = timer_q;
    we_c    = 1'b0;
    if (clear) begin
      state_d = LOAD;
      count_d = '0;
      page_d  = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          page_d  = '0;
          timer_d = '0;
          if (in_valid && in_ready) begin
            we_c    = 1'b1;
            count_d = count_q + CW'(1);
            if (in_last || (count_d == CW'(DEPTH))) state_d = SHOW;
          end
        end
        SHOW: begin
          // Step pulses override the timer; opposing pulses cancel but still restart it.
          if (step_next || step_prev) begin
            timer_d = '0;
            if (step_next && !step_prev)      page_d = page_inc_c;
            else if (step_prev && !step_next) page_d = page_dec_c;
          end else if (mode_auto && !pause) begin
            if (tick_c) begin
              timer_d = '0;
              page_d  = page_inc_c;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_comb begin : p_render
    logic [AW-1:0] idx;
    logic [CW-1:0] pv;
    logic [3:0]    dig;
    hex_d = '1;
    idx   = '0;
    pv    = page_q;
    dig   = 4'hF;
    if (!clear && (state_q == SHOW)) begin
      for (int unsigned k = 0; k < W; k++) begin
        idx = AW'(page_q) * AW'(STEP) + AW'(k);
        dig = (idx < AW'(count_q)) ? buf_q[idx[BW-1:0]] : 4'hF;
        hex_d[7*(W-1-k) +: 7] = seg7(dig);
      end
      for (int unsigned j = 0; j < IDX_DIGITS; j++) begin
        hex_d[7*(W+j) +: 7] = seg7(4'(pv % CW'(10)));
        pv = pv / CW'(10);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      count_q  <= '0;
      page_q   <= '0;
      timer_q  <= '0;
      hex_q    <= '1;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      page_q   <= page_d;
      timer_q  <= timer_d;
      hex_q    <= hex_d;
      loaded_q <= (state_d == SHOW);
    end
  end

  always_ff @(posedge clk) begin
    if (we_c) buf_q[count_q[BW-1:0]] <= in_digit;
  end

  assign hex    = hex_q;
  assign page   = page_q;
  assign count  = count_q;
  assign loaded = loaded_q;

endmodule

// File: doc/digit_scroll_display.md
# digit_scroll_display

Parametrised paged viewer for a buffered decimal digit string on a row of 7-segment displays. It accepts a digit stream from a converter over a valid/ready handshake and stores it up to `DEPTH` digits. It then shows the string one page at a time: a page-index field plus a window of value digits, advanced automatically on a timer or manually by step pulses. It sits between a binary-to-decimal converter and the board HEX outputs in top-level display designs.

## Interface
- `NUM_HEX`, 6, total 7-segment displays driven (3..8)
- `IDX_DIGITS`, 2, displays used for the decimal page index (0..`NUM_HEX`-1); `W` = `NUM_HEX`-`IDX_DIGITS` value digits
- `DEPTH`, 150, digit buffer capacity (1..4095)
- `STEP`, 4, digits advanced per page (1..`W`)
- `TICK_CYCLES`, 50_000_000, clock cycles per auto-advance
- `clk` in 1 system clock, single clock domain
- `rst` in 1 asynchronous, active-high reset
- `clear` in 1 synchronous reset of buffer/view
- `in_valid` in 1 digit present
- `in_digit` in 4 digit value (0-9; 10-15 stored, shown blank)
- `in_last` in 1 final digit of string, qualified by `in_valid`
- `in_ready` out 1 buffer accepting
- `mode_auto` in 1 1 = timed auto-advance, 0 = manual only
- `pause` in 1 freezes auto-advance timer
- `step_next` in 1 one-cycle pulse, next page (pre-synchronised, debounced)
- `step_prev` in 1 one-cycle pulse, previous page
- `hex` out 7*`NUM_HEX` active-low segments gfedcba; display d at `hex[7*d+6:7*d]`, d=`NUM_HEX`-1 leftmost
- `page` out 12 current page number
- `count` out 12 digits stored
- `loaded` out 1 high in SHOW

## Operation
- States: LOAD, SHOW. Reset: LOAD, `count`=0, `page`=0, timer=0, `loaded`=0, `hex` all 7'h7F, `in_ready`=1.
- LOAD: `in_ready` = (`count` < `DEPTH`). A handshake (`in_valid`&`in_ready`) writes `buf[count]`, then `count`+1. Transition to SHOW after a handshake with `in_last`=1, or when `count` reaches `DEPTH`. On entry: `page`=0, timer=0. Display blank throughout LOAD.
- SHOW: `in_ready`=0; `in_valid` ignored. Pages P = ceil(`count`/`STEP`) (P≥1).
- Auto (`mode_auto`=1, `pause`=0): timer counts 0..`TICK_CYCLES`-1. At terminal count, timer wraps to 0 and `page` advances; P-1 wraps to 0. `pause`=1 holds the timer value.
- `step_next`: `page`+1 with wrap P-1→0. `step_prev`: `page`-1 with wrap 0→P-1. Both work in either mode and zero the timer. Both asserted in the same cycle: no page change, timer still zeroed. A step pulse in the same cycle as timer terminal count: step wins, single move.
- Display: value display k (k=0 leftmost of value field) shows `buf[page*STEP+k]` if that index < `count` and the stored value ≤9, else blank. Index field shows `page` in decimal mod 10^`IDX_DIGITS`, leading zeros shown.
- Encoding: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F (hex).
- `clear`: next cycle LOAD, `count`=0, `page`=0, timer=0, `hex` blank. Takes priority over any same-cycle handshake or step.
- `rst` mid-load or mid-show: immediate return to reset values. Buffer contents need no reset.

## Timing
- `in_ready` is combinational from state/`count`. Acceptance is the cycle edge with `in_valid`&`in_ready`. `count` updates the following cycle.
- LOAD→SHOW occurs on the edge accepting the last digit. `loaded` is high the next cycle. `hex` shows page 0 one cycle after that, from registered decode.
- `page` updates on the edge of the step/terminal-count cycle. `hex` follows exactly 1 cycle later.
- Auto period is exactly `TICK_CYCLES` cycles between page changes absent steps/pause.

## Test plan
- Reset (bench `TICK_CYCLES`=4, `DEPTH`=8, defaults otherwise) -> `hex` all 7F, `in_ready`=1, `loaded`=0, `count`=0.
- Load 2,7,1,8,2 with `in_last` on the 5th, `mode_auto`=0 -> `count`=5, P=2. `hex` left→right 40,40,24,78,79,00 (index "00", digits 2718).
- Same string, `mode_auto`=1 -> after 4 cycles page 1: 40,79,24,7F,7F,7F. After 4 more, wraps to page 0. `pause`=1 holds page indefinitely.
- Manual: `step_prev` at page 0 -> page 1. `step_next`+`step_prev` together -> page unchanged.
- Stream 10 digits without `in_last` -> SHOW at `count`=8. `in_ready` low from that cycle. Digits 9-10 are not stored.
- `clear` during SHOW with a same-cycle `step_next`, and `rst` mid-load after 3 digits -> blank `hex`, `count`=0, `loaded`=0, `in_ready`=1.
